// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer and its neighbours in the
// fetch path.
//   PC_W        : architectural PC width
//   BR_NONE     : branch-type encoding for "not a branch" (shared with the BHT)
//   tag_width() : tag width left over after the index and the word offset
package btb_pkg;

  localparam int PC_W = 32;

  localparam logic [2:0] BR_NONE = 3'd0;

  function automatic int tag_width(input int set_bits);
    return PC_W - 2 - set_bits;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid bit, tag and word target (PC[31:2]).
// Two combinational read ports and one write port.
//   clk, rst               : clock, synchronous active-high reset (clears valid)
//   rd_idx, rd_tag         : fetch lookup -> rd_hit, rd_target
//   pr_idx, pr_tag         : EX-stage probe -> pr_hit, pr_valid
//   wr_en, wr_idx, wr_tag,
//   wr_target              : write one entry and mark it valid
module btb_way
  import btb_pkg::*;
#(
  parameter int SET_BITS = 4,
  parameter int TAG_W    = tag_width(SET_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] rd_idx,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic                rd_hit,
  output logic [PC_W-3:0]     rd_target,
  input  logic [SET_BITS-1:0] pr_idx,
  input  logic [TAG_W-1:0]    pr_tag,
  output logic                pr_hit,
  output logic                pr_valid,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [PC_W-3:0]     wr_target
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem [SETS];
  logic [PC_W-3:0]  tgt_mem [SETS];

  // Only the valid bits are reset; tag/target contents are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

  assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_target = tgt_mem[rd_idx];
  assign pr_valid  = valid[pr_idx];
  assign pr_hit    = pr_valid && (tag_mem[pr_idx] == pr_tag);

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer with one LRU bit per set.
// Fetch lookup is combinational; allocation/retarget happens at the clock
// edge when the EX-stage branch resolves taken.
//   clk, rst     : clock, synchronous active-high reset
//   pcF          : fetch PC to look up
//   btb_hit      : valid tag match for pcF (forced 0 during reset)
//   btb_target   : predicted target {stored[29:0], 2'b00}, 0 on miss/reset
//   EXpc, BrNPC  : PC and resolved target of the branch in EX
//   BranchE      : branch in EX resolved taken
//   BranchTypeE  : branch type in EX, BR_NONE = not a branch
// Optional macro BTB_STATS_EN adds stat_lookups, stat_hits, stat_evicts.
module btb_2way
  import btb_pkg::*;
#(
  parameter int SET_BITS = 4,
  parameter int TAG_W    = tag_width(SET_BITS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pcF,
  output logic            btb_hit,
  output logic [PC_W-1:0] btb_target,
  input  logic [PC_W-1:0] EXpc,
  input  logic [PC_W-1:0] BrNPC,
  input  logic            BranchE,
  input  logic [2:0]      BranchTypeE
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_evicts
`endif
);

  localparam int SETS = 1 << SET_BITS;

  logic [SET_BITS-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]    f_tag, e_tag;
  logic [1:0]          f_hit, e_hit, e_valid, wr_en;
  logic [PC_W-3:0]     f_tgt0, f_tgt1, f_tgt;
  logic [SETS-1:0]     lru;
  logic                upd, way_sel, evict;
  logic                unused_ok;

  assign f_idx = pcF[SET_BITS+1:2];
  assign f_tag = pcF[PC_W-1:SET_BITS+2];
  assign e_idx = EXpc[SET_BITS+1:2];
  assign e_tag = EXpc[PC_W-1:SET_BITS+2];

  assign unused_ok = ^{pcF[1:0], EXpc[1:0], BrNPC[1:0]};

  btb_way #(.SET_BITS(SET_BITS), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst(rst),
    .rd_idx(f_idx), .rd_tag(f_tag), .rd_hit(f_hit[0]), .rd_target(f_tgt0),
    .pr_idx(e_idx), .pr_tag(e_tag), .pr_hit(e_hit[0]), .pr_valid(e_valid[0]),
    .wr_en(wr_en[0]), .wr_idx(e_idx), .wr_tag(e_tag), .wr_target(BrNPC[PC_W-1:2])
  );

  btb_way #(.SET_BITS(SET_BITS), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst(rst),
    .rd_idx(f_idx), .rd_tag(f_tag), .rd_hit(f_hit[1]), .rd_target(f_tgt1),
    .pr_idx(e_idx), .pr_tag(e_tag), .pr_hit(e_hit[1]), .pr_valid(e_valid[1]),
    .wr_en(wr_en[1]), .wr_idx(e_idx), .wr_tag(e_tag), .wr_target(BrNPC[PC_W-1:2])
  );

  // Way choice for an update: hitting way first (way0 wins a double match),
  // then first invalid way, then the LRU way.
  always_comb begin
    upd     = BranchE && (BranchTypeE != BR_NONE);
    way_sel = 1'b0;
    if (e_hit[0])        way_sel = 1'b0;
    else if (e_hit[1])   way_sel = 1'b1;
    else if (!e_valid[0]) way_sel = 1'b0;
    else if (!e_valid[1]) way_sel = 1'b1;
    else                 way_sel = lru[e_idx];
    wr_en = '0;
    if (upd && !rst) wr_en[way_sel] = 1'b1;
    evict = upd && !rst && !(|e_hit) && (&e_valid);
  end

  always_comb begin
    f_tgt = '0;
    if (f_hit[0])      f_tgt = f_tgt0;
    else if (f_hit[1]) f_tgt = f_tgt1;
    btb_hit    = !rst && (|f_hit);
    btb_target = rst ? '0 : {f_tgt, 2'b00};
  end

  // Only EX updates touch LRU; the used way becomes MRU.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru <= '0;
    end else if (upd) begin
      lru[e_idx] <= ~way_sel;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_evicts  <= '0;
    end else begin
      stat_lookups <= stat_lookups + 32'd1;
      if (btb_hit) stat_hits   <= stat_hits + 32'd1;
      if (evict)   stat_evicts <= stat_evicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: a recency-list model per set checked on
// every negedge, plus directed vectors with hand-computed expectations.
// Define BTB_STATS_EN for both DUT and bench to cover the statistics ports.
module tb_btb_2way;

  logic        clk, rst;
  logic [31:0] pcF, EXpc, BrNPC, btb_target;
  logic        btb_hit, BranchE;
  logic [2:0]  BranchTypeE;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_evicts;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  btb_2way #(.SET_BITS(4)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .btb_hit(btb_hit), .btb_target(btb_target),
    .EXpc(EXpc), .BrNPC(BrNPC), .BranchE(BranchE), .BranchTypeE(BranchTypeE)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_evicts(stat_evicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each set is a most-recent-first list of at most two (tag, target)
  // pairs. Lookups don't reorder; updates move the entry to the front.
  typedef struct {
    logic [25:0] tag;
    logic [29:0] tgt;
  } ent_t;

  ent_t        sets[16][$];
  int unsigned m_lk, m_ht, m_ev;

  function automatic void mlook(input logic [31:0] pc, output logic h, output logic [31:0] t);
    int unsigned i = pc[5:2];
    h = 1'b0;
    t = '0;
    for (int k = 0; k < sets[i].size(); k++)
      if (sets[i][k].tag == pc[31:6]) begin
        h = 1'b1;
        t = {sets[i][k].tgt, 2'b00};
      end
  endfunction

  task automatic mupd(input logic [31:0] pc, input logic [31:0] npc, output logic ev);
    int unsigned i = pc[5:2];
    int          f = -1;
    ent_t        e;
    ev = 1'b0;
    for (int k = 0; k < sets[i].size(); k++)
      if (sets[i][k].tag == pc[31:6]) f = k;
    if (f >= 0) begin
      sets[i].delete(f);
    end else if (sets[i].size() == 2) begin
      void'(sets[i].pop_back());
      ev = 1'b1;
    end
    e.tag = pc[31:6];
    e.tgt = npc[31:2];
    sets[i].push_front(e);
  endtask

  initial begin
    logic        h, ev;
    logic [31:0] t;
    m_lk = 0; m_ht = 0; m_ev = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 16; i++) sets[i].delete();
        m_lk = 0; m_ht = 0; m_ev = 0;
      end else begin
        mlook(pcF, h, t);
        m_lk++;
        if (h) m_ht++;
        if (BranchE && BranchTypeE != 3'd0) begin
          mupd(EXpc, BrNPC, ev);
          if (ev) m_ev++;
        end
      end
    end
  end

  initial begin
    logic        h;
    logic [31:0] t;
    forever begin
      @(negedge clk);
      if (rst) begin
        h = 1'b0;
        t = '0;
      end else begin
        mlook(pcF, h, t);
      end
      chk("model_hit", {31'd0, btb_hit}, {31'd0, h});
      chk("model_target", btb_target, t);
`ifdef BTB_STATS_EN
      chk("model_lookups", stat_lookups, m_lk);
      chk("model_hits", stat_hits, m_ht);
      chk("model_evicts", stat_evicts, m_ev);
`endif
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] ex, input logic [31:0] npc,
                       input logic be, input logic [2:0] bt);
    pcF = pc; EXpc = ex; BrNPC = npc; BranchE = be; BranchTypeE = bt;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic eh, input logic [31:0] et);
    drive(pc, 32'h0, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    chk({nm, "_hit"}, {31'd0, btb_hit}, {31'd0, eh});
    chk({nm, "_tgt"}, btb_target, et);
    step();
  endtask

  task automatic take(input logic [31:0] ex, input logic [31:0] npc);
    drive(32'h0, ex, npc, 1'b1, 3'd1);
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    step();
    step();
    rst = 1'b0;

    look("cold", 32'h40, 1'b0, 32'h0);

    // Lookup of 0x44 in the same cycle it is first allocated sees the old state.
    drive(32'h44, 32'h44, 32'h100, 1'b1, 3'd1);
    @(negedge clk);
    chk("hazard_hit", {31'd0, btb_hit}, 32'd0);
    step();
    look("alloc", 32'h44, 1'b1, 32'h100);

    drive(32'h44, 32'h44, 32'h300, 1'b0, 3'd1);
    step();
    drive(32'h44, 32'h44, 32'h300, 1'b1, 3'd0);
    step();
    look("not_taken", 32'h44, 1'b1, 32'h100);

    take(32'h84, 32'h180);
    take(32'hC4, 32'h1C0);
    look("evicted_44", 32'h44, 1'b0, 32'h0);
    look("conf_84", 32'h84, 1'b1, 32'h180);
    look("conf_C4", 32'hC4, 1'b1, 32'h1C0);
`ifdef BTB_STATS_EN
    chk("evicts_1", stat_evicts, 32'd1);
`endif

    // Retarget refreshes recency, so the other resident entry becomes victim.
    take(32'h48, 32'h104);
    take(32'h88, 32'h184);
    take(32'h48, 32'h200);
    take(32'hC8, 32'h1C8);
    look("retarget_48", 32'h48, 1'b1, 32'h200);
    look("victim_88", 32'h88, 1'b0, 32'h0);
    look("new_C8", 32'hC8, 1'b1, 32'h1C8);
`ifdef BTB_STATS_EN
    chk("evicts_2", stat_evicts, 32'd2);
`endif

    take(32'h100, 32'h400);
    take(32'h110, 32'h410);
    take(32'h120, 32'h420);
    take(32'h130, 32'h430);
    look("pre_rst_100", 32'h100, 1'b1, 32'h400);

    drive(32'h100, 32'h104, 32'h500, 1'b1, 3'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst_hit", {31'd0, btb_hit}, 32'd0);
    chk("in_rst_tgt", btb_target, 32'h0);
    step();
    rst = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
`ifdef BTB_STATS_EN
    @(negedge clk);
    chk("rst_lookups", stat_lookups, 32'd0);
    chk("rst_hits", stat_hits, 32'd0);
    chk("rst_evicts", stat_evicts, 32'd0);
`endif
    look("rst_100", 32'h100, 1'b0, 32'h0);
    look("rst_110", 32'h110, 1'b0, 32'h0);
    look("rst_120", 32'h120, 1'b0, 32'h0);
    look("rst_130", 32'h130, 1'b0, 32'h0);
    look("rst_104", 32'h104, 1'b0, 32'h0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
